// File: rtl/scan_seq.sv
// rtl/scan_seq.sv - autonomous ADC channel scan sequencer with result FIFO and PCI status/pop port
// Optional continuous scanning is compiled in with `define SCAN_CONT_EN.
module scan_seq #(
    parameter int CH_W     = 6,
    parameter int SETTLE_W = 16,
    parameter int FIFO_AW  = 6,
    parameter int TMO      = 255
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            valid_pci,
    input  logic            rd_wr,
    input  logic            scan_sel,
    input  logic [31:0]     ad_to_tuvv,
    output logic [31:0]     ad_from_tuvv,
    output logic            scan_active,
    output logic [CH_W-1:0] mux_ch,
    output logic            mux_en,
    output logic            adc_start,
    input  logic            adc_valid,
    input  logic [11:0]     adc_data
);

    localparam int TW    = $clog2(TMO + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = CH_W + 12;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_CONVERT, S_WAIT_ADC, S_STORE
    } state_t;

    state_t              state, state_d;
    logic [CH_W-1:0]     cur_ch, first_q, last_q;
    logic [SETTLE_W-1:0] settle_q, settle_cnt;
    logic [TW-1:0]       tmo_cnt;
    logic [11:0]         sample_q;
    logic                done_q, tmo_q, cont_q;

    logic [EW-1:0]       mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    count;
    logic [31:0]         rd_q, rd_word;

    logic wr_cmd, rd_cmd, abort_cmd, start_go, push, pop;
    logic fifo_full, fifo_empty, at_last, adc_hit, adc_tmo, unused_bits;

    assign wr_cmd     = valid_pci & scan_sel & rd_wr;
    assign rd_cmd     = valid_pci & scan_sel & ~rd_wr;
    assign abort_cmd  = wr_cmd & ad_to_tuvv[30];
    assign start_go   = wr_cmd & ad_to_tuvv[31] & ~ad_to_tuvv[30] & (state == S_IDLE);
    assign fifo_full  = (count == (FIFO_AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    // An abort landing on a STORE cycle discards that entry along with the scan.
    assign push       = (state == S_STORE) & ~fifo_full & ~abort_cmd;
    assign pop        = rd_cmd & ~fifo_empty;
    assign at_last    = (cur_ch == last_q);
    assign adc_hit    = (state == S_WAIT_ADC) & adc_valid;
    assign adc_tmo    = (state == S_WAIT_ADC) & ~adc_valid & (tmo_cnt == TW'(TMO - 1));

`ifdef SCAN_CONT_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            cont_q <= 1'b0;
        else if (start_go)
            cont_q <= ad_to_tuvv[23];
    end
    assign unused_bits = ad_to_tuvv[22];
`else
    assign cont_q      = 1'b0;
    assign unused_bits = ^ad_to_tuvv[23:22];
`endif

    always_comb begin
        state_d = state;
        if (abort_cmd) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (start_go) state_d = S_SELECT;
                S_SELECT:   state_d = (settle_q == '0) ? S_CONVERT : S_SETTLE;
                S_SETTLE:   if (settle_cnt == '0) state_d = S_CONVERT;
                S_CONVERT:  state_d = S_WAIT_ADC;
                S_WAIT_ADC: if (adc_hit || adc_tmo) state_d = S_STORE;
                S_STORE:    if (push) state_d = (at_last && !cont_q) ? S_IDLE : S_SELECT;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= S_IDLE;
            cur_ch     <= '0;
            first_q    <= '0;
            last_q     <= '0;
            settle_q   <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            sample_q   <= '0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state <= state_d;
            if (start_go) begin
                cur_ch   <= ad_to_tuvv[24 +: CH_W];
                first_q  <= ad_to_tuvv[24 +: CH_W];
                last_q   <= ad_to_tuvv[16 +: CH_W];
                settle_q <= ad_to_tuvv[SETTLE_W-1:0];
                done_q   <= 1'b0;
                tmo_q    <= 1'b0;
            end
            if (state == S_SELECT)
                settle_cnt <= settle_q - SETTLE_W'(1);
            else if (state == S_SETTLE)
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            if (state == S_CONVERT)
                tmo_cnt <= '0;
            else if (state == S_WAIT_ADC)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (adc_hit)
                sample_q <= adc_data;
            else if (adc_tmo)
                sample_q <= 12'hFFF;
            if (adc_tmo && !abort_cmd)
                tmo_q <= 1'b1;
            if (push) begin
                if (at_last && !cont_q)
                    done_q <= 1'b1;
                else if (at_last)
                    cur_ch <= first_q;
                else
                    cur_ch <= cur_ch + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cur_ch, sample_q};
    end

    always_comb begin
        rd_word = {fifo_empty, scan_active, done_q, tmo_q,
                   count[FIFO_AW] ? 6'd63 : count[5:0],
                   {CH_W{1'b0}}, 4'b0, 12'b0};
        if (!fifo_empty) begin
            rd_word[16 +: CH_W] = mem[rd_ptr][EW-1:12];
            rd_word[11:0]       = mem[rd_ptr][11:0];
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_q   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push && !pop)
                count <= count + (FIFO_AW+1)'(1);
            else if (pop && !push)
                count <= count - (FIFO_AW+1)'(1);
            // Read data is presented for exactly one cycle so the upstream OR-bus stays clean.
            rd_q <= rd_cmd ? rd_word : 32'h0;
        end
    end

    assign ad_from_tuvv = rd_q;
    assign scan_active  = (state != S_IDLE);
    assign mux_en       = (state != S_IDLE);
    assign mux_ch       = cur_ch;
    assign adc_start    = (state == S_CONVERT);

endmodule

// File: tb/tb_scan_seq.sv
// tb/tb_scan_seq.sv - randomized self-checking bench for scan_seq with queue-based reference model
module tb_scan_seq;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        valid_pci = 1'b0;
    logic        rd_wr = 1'b0;
    logic        scan_sel = 1'b0;
    logic [31:0] ad_to_tuvv = 32'h0;
    logic [31:0] ad_from_tuvv;
    logic        scan_active;
    logic [5:0]  mux_ch;
    logic        mux_en;
    logic        adc_start;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = 12'h0;

    scan_seq dut (
        .clk(clk), .rst_(rst_), .valid_pci(valid_pci), .rd_wr(rd_wr), .scan_sel(scan_sel),
        .ad_to_tuvv(ad_to_tuvv), .ad_from_tuvv(ad_from_tuvv), .scan_active(scan_active),
        .mux_ch(mux_ch), .mux_en(mux_en), .adc_start(adc_start),
        .adc_valid(adc_valid), .adc_data(adc_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int adc_lat = 3;
    bit adc_en = 1'b1;
    int adc_cd = 0;
    logic [5:0] lat_ch = 6'd0;
    int sel_cyc = 0;
    logic prev_en = 1'b0;
    logic [5:0] prev_ch = 6'd0;

    logic [5:0]  starts_q[$];
    int          gaps_q[$];
    int          sel_q[$];
    int          start_cyc_q[$];
    logic [5:0]  exp_ch[$];
    logic [11:0] exp_s[$];

    function automatic logic [11:0] smp(input logic [5:0] ch);
        int v;
        v = int'(ch) * 100;
        return v[11:0];
    endfunction

    function automatic logic [31:0] stat_word(input bit e, input bit a, input bit d, input bit t,
                                              input int cnt, input logic [5:0] ch, input logic [11:0] s);
        logic [5:0] c6;
        c6 = cnt[5:0];
        return {e, a, d, t, c6, ch, 4'h0, s};
    endfunction

    function automatic logic [31:0] cmd(input bit st, input bit ab, input int first, input int last,
                                        input int settle, input bit cont);
        logic [5:0] f6, l6;
        logic [15:0] s16;
        f6 = first[5:0];
        l6 = last[5:0];
        s16 = settle[15:0];
        return {st, ab, f6, cont, 1'b0, l6, s16};
    endfunction

    // ADC model plus an observer of selections and conversion requests.
    always @(posedge clk) begin
        #1;
        cyc++;
        adc_valid = 1'b0;
        if (adc_cd > 0) begin
            adc_cd--;
            if (adc_cd == 0 && adc_en) begin
                adc_valid = 1'b1;
                adc_data = smp(lat_ch);
            end
        end
        if (mux_en && (!prev_en || mux_ch != prev_ch)) begin
            sel_cyc = cyc;
            sel_q.push_back(cyc);
        end
        if (adc_start) begin
            starts_q.push_back(mux_ch);
            gaps_q.push_back(cyc - sel_cyc);
            start_cyc_q.push_back(cyc);
            adc_cd = adc_lat;
            lat_ch = mux_ch;
        end
        prev_en = mux_en;
        prev_ch = mux_ch;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] w);
        valid_pci = 1'b1; scan_sel = 1'b1; rd_wr = 1'b1; ad_to_tuvv = w;
        step(1);
        valid_pci = 1'b0; scan_sel = 1'b0; rd_wr = 1'b0; ad_to_tuvv = 32'h0;
    endtask

    task automatic do_read(output logic [31:0] w);
        valid_pci = 1'b1; scan_sel = 1'b1; rd_wr = 1'b0;
        step(1);
        valid_pci = 1'b0; scan_sel = 1'b0;
        w = ad_from_tuvv;
    endtask

    task automatic clear_obs();
        starts_q.delete(); gaps_q.delete(); sel_q.delete(); start_cyc_q.delete();
        exp_ch.delete(); exp_s.delete();
    endtask

    task automatic make_range(input int first, input int last, input bit tmo);
        int ch;
        ch = first;
        forever begin
            exp_ch.push_back(ch[5:0]);
            exp_s.push_back(tmo ? 12'hFFF : smp(ch[5:0]));
            if (ch == last) break;
            ch = (ch + 1) % 64;
        end
    endtask

    task automatic wait_idle(input int max, input string name);
        int n;
        n = 0;
        while (scan_active && n < max) begin
            step(1);
            n++;
        end
        checks++;
        if (scan_active) begin
            failures++;
            $display("FAIL %s_idle_timeout: scan_active=%0b after %0d cycles, required 0", name, scan_active, max);
        end
    endtask

    task automatic check_starts(input string name, input int settle, input bit exact_gap);
        checks++;
        if (starts_q.size() !== exp_ch.size()) begin
            failures++;
            $display("FAIL %s_num_starts: got %0d required %0d", name, starts_q.size(), exp_ch.size());
        end else begin
            foreach (exp_ch[i]) begin
                checks++;
                if (starts_q[i] !== exp_ch[i]) begin
                    failures++;
                    $display("FAIL %s_start_ch[%0d]: got %0d required %0d", name, i, starts_q[i], exp_ch[i]);
                end
                checks++;
                if (gaps_q[i] < settle + 1 || (exact_gap && gaps_q[i] != settle + 1) || gaps_q[i] > settle + 3) begin
                    failures++;
                    $display("FAIL %s_settle_gap[%0d]: got %0d required >= %0d", name, i, gaps_q[i], settle + 1);
                end
            end
        end
    endtask

    task automatic drain_check(input string name, input bit exp_done, input bit exp_tmo);
        logic [31:0] w, e;
        int n;
        n = exp_ch.size();
        for (int i = 0; i < n; i++) begin
            do_read(w);
            e = stat_word(1'b0, 1'b0, exp_done, exp_tmo, n - i, exp_ch[i], exp_s[i]);
            checks++;
            if (w !== e) begin
                failures++;
                $display("FAIL %s_pop[%0d]: got %08h required %08h", name, i, w, e);
            end
        end
        do_read(w);
        e = stat_word(1'b1, 1'b0, exp_done, exp_tmo, 0, 6'd0, 12'd0);
        checks++;
        if (w !== e) begin
            failures++;
            $display("FAIL %s_empty_read: got %08h required %08h", name, w, e);
        end
    endtask

    task automatic test_reset();
        logic [31:0] w;
        step(2);
        checks++;
        if ({ad_from_tuvv, scan_active, mux_ch, mux_en, adc_start} !== 41'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %08h/%b/%0d/%b/%b required all 0",
                     ad_from_tuvv, scan_active, mux_ch, mux_en, adc_start);
        end
        rst_ = 1'b1;
        step(2);
        do_read(w);
        checks++;
        if (w !== 32'h8000_0000) begin
            failures++;
            $display("FAIL reset_status: got %08h required 80000000", w);
        end
        step(1);
        checks++;
        if (ad_from_tuvv !== 32'h0) begin
            failures++;
            $display("FAIL read_hold_one_cycle: got %08h required 00000000", ad_from_tuvv);
        end
        valid_pci = 1'b1; rd_wr = 1'b0; scan_sel = 1'b0;
        step(1);
        valid_pci = 1'b0;
        checks++;
        if (ad_from_tuvv !== 32'h0) begin
            failures++;
            $display("FAIL unselected_read: got %08h required 00000000", ad_from_tuvv);
        end
    endtask

    task automatic test_single_scan();
        clear_obs();
        make_range(2, 5, 1'b0);
        do_write(cmd(1, 0, 2, 5, 10, 0));
        wait_idle(500, "single");
        check_starts("single", 10, 1'b0);
        drain_check("single", 1'b1, 1'b0);
    endtask

    task automatic test_wrap_zero_settle();
        clear_obs();
        make_range(62, 1, 1'b0);
        do_write(cmd(1, 0, 62, 1, 0, 0));
        wait_idle(500, "wrap");
        check_starts("wrap", 0, 1'b1);
        drain_check("wrap", 1'b1, 1'b0);
    endtask

    task automatic test_random_scans();
        int first, len, last, settle;
        for (int it = 0; it < 5; it++) begin
            first = $urandom_range(0, 63);
            len = (it == 0) ? 1 : $urandom_range(1, 20);
            last = (first + len - 1) % 64;
            settle = $urandom_range(0, 6);
            clear_obs();
            make_range(first, last, 1'b0);
            do_write(cmd(1, 0, first, last, settle, 0));
            wait_idle(2000, "random");
            check_starts("random", settle, 1'b0);
            drain_check("random", 1'b1, 1'b0);
        end
    endtask

    task automatic test_start_ignored();
        clear_obs();
        make_range(20, 22, 1'b0);
        do_write(cmd(1, 0, 20, 22, 2, 0));
        step(3);
        do_write(cmd(1, 0, 40, 41, 0, 0));
        wait_idle(500, "restart");
        check_starts("restart", 2, 1'b0);
        drain_check("restart", 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int gap;
        clear_obs();
        adc_en = 1'b0;
        make_range(10, 11, 1'b1);
        do_write(cmd(1, 0, 10, 11, 2, 0));
        wait_idle(2000, "timeout");
        adc_en = 1'b1;
        check_starts("timeout", 2, 1'b0);
        checks++;
        gap = (sel_q.size() >= 2 && start_cyc_q.size() >= 1) ? sel_q[1] - start_cyc_q[0] : -1;
        if (gap < 256 || gap > 258) begin
            failures++;
            $display("FAIL timeout_duration: got %0d cycles required 256..258", gap);
        end
        drain_check("timeout", 1'b1, 1'b1);
        clear_obs();
        make_range(5, 5, 1'b0);
        do_write(cmd(1, 0, 5, 5, 0, 0));
        wait_idle(500, "tmo_clear");
        drain_check("tmo_clear", 1'b1, 1'b0);
    endtask

    task automatic test_fifo_full();
        logic [31:0] w, e;
        int guard;
        clear_obs();
        do_write(cmd(1, 0, 0, 63, 0, 0));
        wait_idle(3000, "full_pass1");
        starts_q.delete();
        do_write(cmd(1, 0, 0, 63, 0, 0));
        step(40);
        checks++;
        if ({scan_active, mux_en, mux_ch} !== {1'b1, 1'b1, 6'd0} || starts_q.size() != 1) begin
            failures++;
            $display("FAIL full_stall: active=%b en=%b ch=%0d starts=%0d required 1 1 0 1",
                     scan_active, mux_en, mux_ch, starts_q.size());
        end
        do_read(w);
        e = stat_word(1'b0, 1'b1, 1'b0, 1'b0, 63, 6'd0, smp(6'd0));
        checks++;
        if (w !== e) begin
            failures++;
            $display("FAIL full_first_pop: got %08h required %08h", w, e);
        end
        make_range(1, 63, 1'b0);
        make_range(0, 63, 1'b0);
        guard = 0;
        forever begin
            do_read(w);
            guard++;
            if (w[31] && !w[30]) break;
            if (guard > 3000) begin
                checks++;
                failures++;
                $display("FAIL full_drain_timeout: %0d reads, required scan to finish", guard);
                break;
            end
            if (!w[31]) begin
                checks++;
                if (exp_ch.size() == 0) begin
                    failures++;
                    $display("FAIL full_extra_entry: got ch %0d required none", w[21:16]);
                end else begin
                    if (w[21:16] !== exp_ch[0] || w[11:0] !== exp_s[0]) begin
                        failures++;
                        $display("FAIL full_entry: got %0d/%03h required %0d/%03h",
                                 w[21:16], w[11:0], exp_ch[0], exp_s[0]);
                    end
                    void'(exp_ch.pop_front());
                    void'(exp_s.pop_front());
                end
            end
        end
        checks++;
        if (exp_ch.size() != 0 || w[29] !== 1'b1) begin
            failures++;
            $display("FAIL full_lost_entries: got %0d missing done=%b required 0 missing done=1",
                     exp_ch.size(), w[29]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] w;
        int n;
        clear_obs();
        adc_lat = 6;
        do_write(cmd(1, 0, 20, 30, 3, 0));
        n = 0;
        while (!adc_start && n < 100) begin
            step(1);
            n++;
        end
        step(1);
        do_write(cmd(0, 1, 0, 0, 0, 0));
        checks++;
        if ({scan_active, mux_en, adc_start} !== 3'b000) begin
            failures++;
            $display("FAIL abort_next_cycle: got active=%b en=%b start=%b required 000",
                     scan_active, mux_en, adc_start);
        end
        step(10);
        do_read(w);
        checks++;
        if (w !== 32'h8000_0000 || starts_q.size() != 1) begin
            failures++;
            $display("FAIL abort_late_valid: got %08h starts=%0d required 80000000 starts=1", w, starts_q.size());
        end
        adc_lat = 3;
        do_write(cmd(1, 1, 7, 9, 0, 0));
        step(5);
        checks++;
        if (scan_active !== 1'b0 || starts_q.size() != 1) begin
            failures++;
            $display("FAIL start_plus_abort: got active=%b starts=%0d required 0 and 1", scan_active, starts_q.size());
        end
    endtask

    task automatic test_cont();
        logic [31:0] w;
        int k, guard;
`ifdef SCAN_CONT_EN
        clear_obs();
        do_write(cmd(1, 0, 3, 4, 1, 1));
        k = 0;
        guard = 0;
        while (starts_q.size() < 12 && guard < 2000) begin
            do_read(w);
            guard++;
            if (!w[31]) begin
                checks++;
                if (w[21:16] !== ((k % 2 == 0) ? 6'd3 : 6'd4) || w[29] !== 1'b0) begin
                    failures++;
                    $display("FAIL cont_pop[%0d]: got ch %0d done %b required ch %0d done 0",
                             k, w[21:16], w[29], (k % 2 == 0) ? 3 : 4);
                end
                k++;
            end
        end
        do_write(cmd(0, 1, 0, 0, 0, 0));
        checks++;
        if (starts_q.size() < 12 || scan_active !== 1'b0) begin
            failures++;
            $display("FAIL cont_run: got starts=%0d active=%b required >=12 and 0", starts_q.size(), scan_active);
        end
        for (int i = 0; i < starts_q.size(); i++) begin
            checks++;
            if (starts_q[i] !== ((i % 2 == 0) ? 6'd3 : 6'd4)) begin
                failures++;
                $display("FAIL cont_seq[%0d]: got %0d required %0d", i, starts_q[i], (i % 2 == 0) ? 3 : 4);
            end
        end
        do {
            do_read(w);
            guard++;
        } while (!w[31] && guard < 3000);
        checks++;
        if (w[31] !== 1'b1 || w[29] !== 1'b0) begin
            failures++;
            $display("FAIL cont_done: got empty=%b done=%b required 1 0", w[31], w[29]);
        end
`else
        k = 0;
        guard = 0;
        clear_obs();
        make_range(3, 4, 1'b0);
        do_write(cmd(1, 0, 3, 4, 1, 1));
        wait_idle(500 + k + guard, "cont_ignored");
        check_starts("cont_ignored", 1, 1'b0);
        drain_check("cont_ignored", 1'b1, 1'b0);
`endif
    endtask

    task automatic test_async_reset();
        logic [31:0] w;
        clear_obs();
        do_write(cmd(1, 0, 0, 10, 1, 0));
        step(20);
        #3;
        rst_ = 1'b0;
        #1;
        checks++;
        if ({ad_from_tuvv, scan_active, mux_ch, mux_en, adc_start} !== 41'h0) begin
            failures++;
            $display("FAIL async_reset: got %08h/%b/%0d/%b/%b required all 0",
                     ad_from_tuvv, scan_active, mux_ch, mux_en, adc_start);
        end
        step(1);
        rst_ = 1'b1;
        step(2);
        do_read(w);
        checks++;
        if (w !== 32'h8000_0000) begin
            failures++;
            $display("FAIL async_reset_status: got %08h required 80000000", w);
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_wrap_zero_settle();
        test_random_scans();
        test_start_ignored();
        test_timeout();
        test_fifo_full();
        test_abort();
        test_cont();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_seq.md
Name: scan_seq

Overview:
- Autonomous measurement scan sequencer. Steps the input multiplexer across a channel range; for each channel it waits a programmable settle time, triggers one ADC conversion and pushes {channel, sample} into an internal result FIFO.
- Host programs and reads it over the decoded PCI target path (valid_pci, rd_wr, ad_to_tuvv/ad_from_tuvv) using its own address-select strobe from adr_sel.
- This frees the host from per-channel PCI traffic.

Parameters:
- CH_W, 6, channel index width (channels 0..2^CH_W-1)
- SETTLE_W, 16, settle counter width (cycles of clk)
- FIFO_AW, 6, result FIFO address width (depth 2^FIFO_AW = 64)
- TMO, 255, max clk cycles waiting for adc_valid before timeout

Ports:
- clk  in  1  system clock (PCI clock)
- rst_  in  1  reset, asynchronous, active-low
- valid_pci  in  1  PCI data phase valid
- rd_wr  in  1  1 = host write, 0 = host read
- scan_sel  in  1  address decode strobe for this block
- ad_to_tuvv  in  32  host write data
- ad_from_tuvv  out  32  host read data (0 when not selected; OR-combined upstream)
- scan_active  out  1  sequencer not IDLE
- mux_ch  out  CH_W  selected input channel
- mux_en  out  1  input mux enable
- adc_start  out  1  one-cycle conversion request
- adc_valid  in  1  one-cycle pulse, adc_data valid
- adc_data  in  12  conversion result

Behaviour:
- Reset values: ad_from_tuvv=0, scan_active=0, mux_ch=0, mux_en=0, adc_start=0. FIFO empty; done=0, tmo_flag=0.
- Control write: valid_pci & scan_sel & rd_wr.
  - Bit fields: [31] start, [30] abort, [29:24] first_ch, [21:16] last_ch, [15:0] settle.
  - Abort has priority over start. Start while scan_active=1 is ignored. Abort in IDLE is a no-op.
  - Start clears done and tmo_flag. It does not flush the FIFO.
- Status/pop read: valid_pci & scan_sel & ~rd_wr.
  - Returns, registered one cycle later and held one cycle: {[31] fifo_empty, [30] scan_active, [29] done, [28] tmo_flag, [27:22] fifo_count[5:0] (saturating 63), [21:16] ch, [15:12] 0, [11:0] sample}.
  - If the FIFO is non-empty, the head entry is popped. If empty, ch/sample read as 0 and no pop occurs.
- States:
  - IDLE: start -> SELECT, with cur_ch=first_ch.
  - SELECT: mux_ch=cur_ch, mux_en=1; settle=0 -> CONVERT, else -> SETTLE.
  - SETTLE: count settle cycles -> CONVERT.
  - CONVERT: adc_start=1 for exactly one cycle -> WAIT_ADC.
  - WAIT_ADC: adc_valid -> STORE (latch adc_data). After TMO cycles without adc_valid: set tmo_flag, latch sample 0xFFF -> STORE.
  - STORE: push {cur_ch, sample} when FIFO not full; if full, stall in STORE (no data loss, mux stays selected). Then: cur_ch==last_ch -> IDLE with done=1, mux_en=0; else cur_ch=cur_ch+1 mod 2^CH_W -> SELECT.
- Range rules:
  - first_ch>last_ch wraps through max channel to 0.
  - first_ch==last_ch scans exactly one channel.
- Abort takes effect on the next cycle from any state: -> IDLE, mux_en=0, adc_start=0, done not set. A conversion in flight is discarded; a late adc_valid in IDLE is ignored.
- FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pop from empty is impossible.
- Asynchronous reset mid-scan returns all state and outputs to reset values immediately.

Optional Feature:
- Macro: SCAN_CONT_EN.
- Defined:
  - Write bit [23] = cont.
  - With cont=1, STORE at last_ch returns to SELECT with cur_ch=first_ch instead of IDLE; done is never set. The scan runs until abort.
  - FIFO-full stall still applies.
- Undefined: bit [23] is ignored and every scan is single-pass.

Test Plan:
- Single scan: write start, first=2, last=5, settle=10; ADC model answers 3 cycles after adc_start with data=ch*100 -> mux_ch 2,3,4,5; each adc_start 11+ cycles after SELECT. Four reads give ch/sample (2,200)..(5,500), then a read gives fifo_empty=1 and done=1.
- Wrap and zero settle: first=62, last=1, settle=0 -> channels 62,63,0,1 in order; adc_start the cycle after SELECT.
- Timeout: ADC never returns valid -> after 255 cycles entry sample=0xFFF, tmo_flag=1, scan continues to the next channel.
- FIFO full stall: scan 0..63 twice without reads -> second pass stalls in STORE at its first channel with fifo_count=63 (64 entries). One read pops ch 0 and the scan resumes; no entry lost or duplicated.
- Abort: abort during WAIT_ADC -> next cycle scan_active=0, mux_en=0, done=0. A late adc_valid is not stored; start+abort in the same write leaves the block IDLE.
- SCAN_CONT_EN: cont=1, first=3, last=4, with reads keeping pace -> sequence 3,4,3,4,... continues until abort; done stays 0.
